mac_tx_ifc: RTL and testbench
=============================

MAC_TX_IFC -- requirements
Module: mac_tx_ifc

Interface
REQ-001 Parameter IPG_DIBITS, default 48, inter-frame gap length in clocks (96 bit times).
REQ-002 Parameter MIN_BYTES, default 60, minimum frame length in bytes before the FCS; shorter frames are padded.
REQ-003 clk  input  1  single clock; all logic is on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pktbuf  input  [1517:0][7:0]  frame bytes, destination MAC first, byte 0 first on the wire.
REQ-006 pktbuf_maxaddr  input  11  index of the last payload byte to send, FCS excluded.
REQ-007 doorbell  input  1  request to send one frame; sampled only in IDLE.
REQ-008 tx_axi_valid  output  1  high for every clock that carries a dibit.
REQ-009 tx_axi_data  output  2  transmit dibit.
REQ-010 busy  output  1  high from the doorbell accept until the end of the IPG.
REQ-011 done  output  1  one-cycle pulse when the frame and its IPG are complete.

Function
REQ-012 The block SHALL use six states: IDLE, PREAMBLE, DATA, PAD, FCS, IPG.
REQ-013 In IDLE with doorbell=1 at edge N, the block SHALL latch min(pktbuf_maxaddr, 1513), enter PREAMBLE, set busy=1, and drive the first dibit with tx_axi_valid=1 from edge N.
REQ-014 Doorbell SHALL be ignored in every state except IDLE, with no queuing.
REQ-015 pktbuf SHALL be read live, not snapshotted; the caller holds it stable while busy=1.
REQ-016 PREAMBLE SHALL send 31 dibits of 2'b01 and then 1 dibit of 2'b11 (7x 0x55 followed by SFD 0xD5), 32 clocks in total.
REQ-017 Every byte SHALL be sent LSB-first as four dibits: bits [1:0], [3:2], [5:4], [7:6]. A 2-bit dibit counter wraps 3->0 and increments the byte address on wrap.
REQ-018 DATA SHALL send bytes 0..latched_maxaddr. If latched_maxaddr+1 < MIN_BYTES, PAD SHALL then send 0x00 bytes until MIN_BYTES bytes have been sent; otherwise the block SHALL go straight to FCS.
REQ-019 CRC-32 SHALL use the reflected polynomial 0xEDB88320 with initial value 0xFFFFFFFF, cover DATA and PAD bytes only, and update 2 bits per clock in transmit order.
REQ-020 FCS SHALL send ~crc as 16 dibits, bits [1:0] first and [31:30] last, with the CRC register frozen during FCS.
REQ-021 IPG SHALL hold tx_axi_valid=0, tx_axi_data=2'b00 and busy=1 for IPG_DIBITS clocks.
REQ-022 On the last IPG clock the block SHALL pulse done=1 for one cycle; on the next edge busy=0 and the state is IDLE.
REQ-023 tx_axi_valid SHALL be continuous (no gaps) from the first preamble dibit to the last FCS dibit; valid clocks = 32 + 4*max(maxaddr+1, MIN_BYTES) + 16.
REQ-024 Outside PREAMBLE/DATA/PAD/FCS, tx_axi_data SHALL be 2'b00.
REQ-025 The byte address SHALL be 11 bits wide and never exceed 1513.

Reset
REQ-026 Asserting rst SHALL immediately (asynchronously) force state IDLE, tx_axi_valid=0, tx_axi_data=0, busy=0, done=0, all counters 0, and CRC 0xFFFFFFFF.
REQ-027 Reset asserted mid-frame SHALL truncate the frame with no FCS and no IPG; the first doorbell after deassertion SHALL start a clean frame.

Verification
REQ-028 maxaddr=0, pktbuf[0]=0xAB -> 32 preamble dibits, then 11,10,10,10, then 59 zero bytes, 16 FCS dibits; 288 valid clocks; FCS matches the golden CRC-32 of the 60 bytes.
REQ-029 maxaddr=99 with random bytes -> no PAD, 32+400+16=448 valid clocks; a dibit-to-byte reassembly matches pktbuf[0..99] and the FCS matches the golden model.
REQ-030 maxaddr=2047 -> clamped to 1513; 32+6056+16=6104 valid clocks.
REQ-031 Doorbell held high for the whole frame -> exactly one frame, 48 IPG clocks with valid=0, one done pulse, and the second frame starts the clock after busy falls.
REQ-032 rst pulsed at DATA dibit 10 -> valid=0 in the same cycle with no FCS; the next doorbell produces a full, correct frame.
REQ-033 Loopback of random frames (maxaddr 0..1513) into the receive chain -> doorbell asserted with a received maxaddr equal to max(maxaddr, 59) and matching bytes.

Source files
------------

// File: rtl/mac_tx_ifc.sv
// RMII-style transmit framer: preamble, payload, zero pad, CRC-32 FCS, IPG.
// Emits one dibit per clock, LSB-first within each byte.
module mac_tx_ifc #(
  parameter int IPG_DIBITS = 48,
  parameter int MIN_BYTES  = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1517:0][7:0] pktbuf,
  input  logic [10:0]        pktbuf_maxaddr,
  input  logic               doorbell,
  output logic               tx_axi_valid,
  output logic [1:0]         tx_axi_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA, PAD, FCS, IPG
  } state_t;

  localparam logic [10:0] MAX_ADDR = 11'd1513;
  localparam logic [10:0] PAD_LAST = 11'(MIN_BYTES - 1);
  localparam logic [11:0] MIN_LEN  = 12'(MIN_BYTES);
  localparam logic [15:0] IPG_LAST = 16'(IPG_DIBITS - 1);
  localparam logic [31:0] POLY     = 32'hEDB88320;

  state_t      state;
  logic [4:0]  cnt;
  logic [10:0] addr;
  logic [10:0] maxaddr_q;
  logic [1:0]  dib;
  logic [31:0] crc;
  logic [15:0] ipg_cnt;

  logic [7:0]  cur_byte;
  logic [1:0]  dib_inc;
  logic [1:0]  cur_next;
  logic [1:0]  nxt_first;
  logic        short_frame;
  logic [31:0] crc_inv;
  logic [3:0]  fcs_idx;
  logic [1:0]  fcs_next;
  logic [10:0] clamp;

  // Reflected CRC-32, bit 0 of the dibit goes on the wire first.
  function automatic logic [31:0] crc_dibit(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    cur_byte    = pktbuf[addr];
    nxt_first   = pktbuf[addr + 11'd1][1:0];
    dib_inc     = dib + 2'd1;
    cur_next    = 2'(cur_byte >> {dib_inc, 1'b0});
    short_frame = ({1'b0, addr} + 12'd1) < MIN_LEN;
    crc_inv     = ~crc;
    fcs_idx     = cnt[3:0] + 4'd1;
    fcs_next    = 2'(crc_inv >> {fcs_idx, 1'b0});
    clamp       = (pktbuf_maxaddr > MAX_ADDR) ? MAX_ADDR : pktbuf_maxaddr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      maxaddr_q    <= '0;
      dib          <= '0;
      crc          <= '1;
      ipg_cnt      <= '0;
      tx_axi_valid <= 1'b0;
      tx_axi_data  <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (doorbell) begin
            state        <= PREAMBLE;
            maxaddr_q    <= clamp;
            cnt          <= '0;
            addr         <= '0;
            dib          <= '0;
            crc          <= '1;
            busy         <= 1'b1;
            tx_axi_valid <= 1'b1;
            tx_axi_data  <= 2'b01;
          end
        end
        PREAMBLE: begin
          if (cnt == 5'd31) begin
            state       <= DATA;
            tx_axi_data <= cur_byte[1:0];
            crc         <= crc_dibit(crc, cur_byte[1:0]);
          end else begin
            cnt         <= cnt + 5'd1;
            tx_axi_data <= (cnt == 5'd30) ? 2'b11 : 2'b01;
          end
        end
        DATA: begin
          if (dib != 2'd3) begin
            dib         <= dib_inc;
            tx_axi_data <= cur_next;
            crc         <= crc_dibit(crc, cur_next);
          end else if (addr != maxaddr_q) begin
            addr        <= addr + 11'd1;
            dib         <= '0;
            tx_axi_data <= nxt_first;
            crc         <= crc_dibit(crc, nxt_first);
          end else if (short_frame) begin
            state       <= PAD;
            addr        <= addr + 11'd1;
            dib         <= '0;
            tx_axi_data <= 2'b00;
            crc         <= crc_dibit(crc, 2'b00);
          end else begin
            state       <= FCS;
            cnt         <= '0;
            tx_axi_data <= crc_inv[1:0];
          end
        end
        PAD: begin
          if (dib != 2'd3) begin
            dib         <= dib_inc;
            tx_axi_data <= 2'b00;
            crc         <= crc_dibit(crc, 2'b00);
          end else if (addr != PAD_LAST) begin
            addr        <= addr + 11'd1;
            dib         <= '0;
            tx_axi_data <= 2'b00;
            crc         <= crc_dibit(crc, 2'b00);
          end else begin
            state       <= FCS;
            cnt         <= '0;
            tx_axi_data <= crc_inv[1:0];
          end
        end
        FCS: begin
          if (cnt == 5'd15) begin
            state        <= IPG;
            cnt          <= '0;
            ipg_cnt      <= '0;
            tx_axi_valid <= 1'b0;
            tx_axi_data  <= 2'b00;
            done         <= (IPG_LAST == 16'd0);
          end else begin
            cnt         <= cnt + 5'd1;
            tx_axi_data <= fcs_next;
          end
        end
        IPG: begin
          if (ipg_cnt == IPG_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ipg_cnt <= '0;
            addr    <= '0;
            dib     <= '0;
          end else begin
            ipg_cnt <= ipg_cnt + 16'd1;
            done    <= ((ipg_cnt + 16'd1) == IPG_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_ifc.sv
// Directed bench for mac_tx_ifc: frame shape, padding, clamp, FCS,
// doorbell hold, IPG/done timing and mid-frame reset.
module tb_mac_tx_ifc;

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic               clk;
  logic               rst;
  logic [1517:0][7:0] pktbuf;
  logic [10:0]        pktbuf_maxaddr;
  logic               doorbell;
  logic               tx_axi_valid;
  logic [1:0]         tx_axi_data;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  logic [1:0] dq[$];

  mac_tx_ifc dut (
    .clk            (clk),
    .rst            (rst),
    .pktbuf         (pktbuf),
    .pktbuf_maxaddr (pktbuf_maxaddr),
    .doorbell       (doorbell),
    .tx_axi_valid   (tx_axi_valid),
    .tx_axi_data    (tx_axi_data),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Bytewise reference CRC-32 over payload then zero pad.
  function automatic logic [31:0] golden(input int ma, input int nb);
    logic [31:0] c;
    logic [7:0]  b;
    c = '1;
    for (int i = 0; i < nb; i++) begin
      b = (i <= ma) ? pktbuf[i] : 8'h00;
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic capture(input bit hold, input bit started,
                         input string tag);
    int n = 0;
    dq.delete();
    if (!started) begin
      @(negedge clk);
      doorbell = 1'b1;
      @(negedge clk);
      doorbell = hold;
    end
    check({tag, ".start"}, {31'd0, tx_axi_valid}, 32'd1);
    while (tx_axi_valid && n < 8000) begin
      dq.push_back(tx_axi_data);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic verify(input string tag, input int ma_in);
    int ma;
    int nb;
    int pe = 0;
    int de = 0;
    int base;
    logic [7:0]  bt;
    logic [7:0]  ex;
    logic [31:0] f;
    ma = (ma_in > 1513) ? 1513 : ma_in;
    nb = (ma + 1 < 60) ? 60 : ma + 1;
    check({tag, ".len"}, dq.size(), 32 + 4 * nb + 16);
    if (dq.size() == 32 + 4 * nb + 16) begin
      for (int i = 0; i < 32; i++)
        if (dq[i] !== ((i == 31) ? 2'b11 : 2'b01)) pe++;
      check({tag, ".pre"}, pe, 0);
      for (int b = 0; b < nb; b++) begin
        base = 32 + 4 * b;
        bt = {dq[base + 3], dq[base + 2], dq[base + 1], dq[base]};
        ex = (b <= ma) ? pktbuf[b] : 8'h00;
        if (bt !== ex) de++;
      end
      check({tag, ".data"}, de, 0);
      f = '0;
      for (int k = 0; k < 16; k++)
        f[2 * k +: 2] = dq[32 + 4 * nb + k];
      check({tag, ".fcs"}, f, golden(ma, nb));
    end
  endtask

  initial begin
    int ipg;
    int dn;
    int dpos;
    int k;
    rst = 1'b1;
    doorbell = 1'b0;
    pktbuf = '0;
    pktbuf_maxaddr = '0;
    repeat (3) @(negedge clk);
    check("rst.valid", {31'd0, tx_axi_valid}, 32'd0);
    check("rst.data", {30'd0, tx_axi_data}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // One-byte frame, pad must ignore the rest of the buffer.
    for (int i = 0; i < 1518; i++) pktbuf[i] = 8'hFF;
    pktbuf[0] = 8'hAB;
    pktbuf_maxaddr = 11'd0;
    capture(0, 0, "pad");
    check("pad.d0", {24'd0, dq[32], dq[33], dq[34], dq[35]},
          {24'd0, 8'b11_10_10_10});
    verify("pad", 0);
    wait_idle("pad");

    // 100-byte frame, no pad.
    for (int i = 0; i < 1518; i++) pktbuf[i] = 8'($urandom);
    pktbuf_maxaddr = 11'd99;
    capture(0, 0, "f100");
    verify("f100", 99);
    wait_idle("f100");

    // Oversize index clamps to 1513.
    pktbuf_maxaddr = 11'd2047;
    capture(0, 0, "big");
    verify("big", 2047);
    wait_idle("big");

    // Doorbell held through the whole frame.
    pktbuf_maxaddr = 11'd0;
    capture(1, 0, "hold");
    verify("hold", 0);
    ipg = 0;
    dn = 0;
    dpos = 0;
    k = 0;
    while (busy && k < 200) begin
      if (!tx_axi_valid) ipg++;
      if (done) begin
        dn++;
        dpos = ipg;
      end
      k++;
      @(negedge clk);
    end
    check("hold.ipg", ipg, 48);
    check("hold.done_n", dn, 1);
    check("hold.done_pos", dpos, 48);
    check("hold.gap", {31'd0, tx_axi_valid}, 32'd0);
    @(negedge clk);
    doorbell = 1'b0;
    capture(0, 1, "hold2");
    verify("hold2", 0);
    wait_idle("hold2");

    // Reset on DATA dibit 10 truncates the frame.
    pktbuf_maxaddr = 11'd99;
    @(negedge clk);
    doorbell = 1'b1;
    @(negedge clk);
    doorbell = 1'b0;
    repeat (42) @(negedge clk);
    check("mid.valid_pre", {31'd0, tx_axi_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid.valid", {31'd0, tx_axi_valid}, 32'd0);
    check("mid.data", {30'd0, tx_axi_data}, 32'd0);
    check("mid.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pktbuf_maxaddr = 11'd20;
    capture(0, 0, "after");
    verify("after", 20);
    wait_idle("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
